// File: rtl/leia_img_pkg.sv
// Shared image-pipeline types, widths and Sobel helpers.
// Imported by the edge detector and its line buffers.
package leia_img_pkg;

    localparam int PX_W   = 8;
    localparam int GRAD_W = 11;
    localparam int MAG_W  = 11;
    localparam int FILL_W = 13;

    localparam logic signed [GRAD_W-1:0] SOBEL_K_SIDE = 11'sd1;
    localparam logic signed [GRAD_W-1:0] SOBEL_K_MID  = 11'sd2;

    // Weighted 1-2-1 sum of three pixels; max 1020, fits signed 11 bits.
    function automatic logic signed [GRAD_W-1:0] sobel_tap(
        input logic [PX_W-1:0] a,
        input logic [PX_W-1:0] b,
        input logic [PX_W-1:0] c
    );
        logic signed [GRAD_W-1:0] sa, sb, sc;
        sa = $signed({{(GRAD_W-PX_W){1'b0}}, a});
        sb = $signed({{(GRAD_W-PX_W){1'b0}}, b});
        sc = $signed({{(GRAD_W-PX_W){1'b0}}, c});
        return sa * SOBEL_K_SIDE + sb * SOBEL_K_MID + sc * SOBEL_K_SIDE;
    endfunction

    function automatic logic [MAG_W-1:0] abs_grad(
        input logic signed [GRAD_W-1:0] g
    );
        return g[GRAD_W-1] ? MAG_W'(-g) : MAG_W'(g);
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Fixed-length delay line: dout is din from DEPTH accepted samples ago.
// Only the pointer is reset; stale contents are hidden downstream.
module sobel_line_buffer #(
    parameter int DEPTH = 520,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (ena) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ena) begin
            mem[ptr_q] <= din;
        end
    end

    assign dout = mem[ptr_q];

endmodule

// File: rtl/sobel_edge_detect.sv
// Streaming 3x3 Sobel edge detector with |Gx|+|Gy| threshold.
// Optional SOBEL_BORDER_SUPPRESS_EN zeroes centre columns 0 and last.
module sobel_edge_detect
    import leia_img_pkg::*;
#(
    parameter logic [15:0] PX_PER_ROW     = 16'd520,
    parameter logic [7:0]  DEFAULT_THRESH = 8'd100
) (
    input  logic       CLK100MHZ,
    input  logic       btn_reset,
    input  logic       ena,
    input  logic [7:0] px_in,
    input  logic [7:0] thresh_in,
    output logic       edge_px,
    output logic       edge_valid
);

`ifdef SOBEL_BORDER_SUPPRESS_EN
    localparam bit BORDER_SUPPRESS = 1'b1;
`else
    localparam bit BORDER_SUPPRESS = 1'b0;
`endif

    localparam int W = int'(PX_PER_ROW);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(2 * W + 5);
    localparam logic [15:0] COL_LAST = PX_PER_ROW - 16'd1;

    logic [PX_W-1:0] line1_out, line2_out;

    logic [2:0][2:0][PX_W-1:0] win_q, win_d;
    logic signed [GRAD_W-1:0]  gx_q, gx_d, gy_q, gy_d;
    logic [FILL_W-1:0]         fill_q, fill_d;
    logic                      valid_q, valid_d;
    logic                      edge_q, edge_d;
    logic [15:0]               col_q, col_d;
    logic [15:0]               wcol_q, wcol_d;
    logic [15:0]               gcol_q, gcol_d;
    logic [MAG_W-1:0]          mag;
    logic                      border;

    sobel_line_buffer #(.DEPTH(W), .WIDTH(PX_W)) u_line1 (
        .clk  (CLK100MHZ),
        .rst  (btn_reset),
        .ena  (ena),
        .din  (px_in),
        .dout (line1_out)
    );

    sobel_line_buffer #(.DEPTH(W), .WIDTH(PX_W)) u_line2 (
        .clk  (CLK100MHZ),
        .rst  (btn_reset),
        .ena  (ena),
        .din  (line1_out),
        .dout (line2_out)
    );

    assign mag    = abs_grad(gx_q) + abs_grad(gy_q);
    assign border = (gcol_q == 16'd0) || (gcol_q == COL_LAST);

    always_comb begin
        win_d   = win_q;
        gx_d    = gx_q;
        gy_d    = gy_q;
        fill_d  = fill_q;
        valid_d = valid_q;
        edge_d  = edge_q;
        col_d   = col_q;
        wcol_d  = wcol_q;
        gcol_d  = gcol_q;
        if (ena) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = line2_out;
            win_d[1][2] = line1_out;
            win_d[2][2] = px_in;
            // col_q is the incoming column; the centre lags it by one.
            col_d  = (col_q == COL_LAST) ? 16'd0 : col_q + 16'd1;
            wcol_d = (col_q == 16'd0) ? COL_LAST : col_q - 16'd1;
            gx_d = sobel_tap(win_q[0][2], win_q[1][2], win_q[2][2])
                 - sobel_tap(win_q[0][0], win_q[1][0], win_q[2][0]);
            gy_d = sobel_tap(win_q[2][0], win_q[2][1], win_q[2][2])
                 - sobel_tap(win_q[0][0], win_q[0][1], win_q[0][2]);
            gcol_d  = wcol_q;
            fill_d  = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
            valid_d = valid_q || (fill_q == FILL_MAX - 1'b1);
            edge_d  = valid_d
                   && (mag > {3'b000, thresh_in})
                   && !(BORDER_SUPPRESS && border);
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (btn_reset) begin
            win_q   <= '0;
            gx_q    <= '0;
            gy_q    <= '0;
            fill_q  <= '0;
            valid_q <= 1'b0;
            edge_q  <= 1'b0;
            col_q   <= '0;
            wcol_q  <= '0;
            gcol_q  <= '0;
        end else begin
            win_q   <= win_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
            edge_q  <= edge_d;
            col_q   <= col_d;
            wcol_q  <= wcol_d;
            gcol_q  <= gcol_d;
        end
    end

    assign edge_px    = edge_q;
    assign edge_valid = valid_q;

endmodule
